// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage plus MEM/WB pipeline register.
// Runs word loads/stores to an external SRAM over a req/ack handshake that
// is bounded by a wait-cycle timeout. While an access is in flight, freeze
// stalls the upstream pipeline. The MEM/WB register feeds write-back and
// receives a bubble in every cycle where no instruction retires.
module mem_access_stage #(
  parameter int DATA_W      = 32,
  parameter int DEST_W      = 4,
  parameter int SRAM_ADDR_W = 16,
  parameter int MEM_BASE    = 1024,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic [DATA_W-1:0]      alu_res_in,
  input  logic [DATA_W-1:0]      val_Rm_in,
  input  logic [DEST_W-1:0]      dest_in,
  output logic                   sram_req,
  output logic                   sram_we,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  input  logic [DATA_W-1:0]      sram_rdata,
  input  logic                   sram_ack,
  output logic                   freeze,
  output logic                   mem_err,
  output logic                   wb_en_out,
  output logic                   mem_r_en_out,
  output logic [DATA_W-1:0]      alu_res_out,
  output logic [DATA_W-1:0]      mem_data_out,
  output logic [DEST_W-1:0]      dest_out
);

  // The wait counter must be able to hold TIMEOUT-1, the index of the last
  // WAIT cycle before the access is abandoned.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] BASE     = DATA_W'(MEM_BASE);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Byte address to SRAM word index. Offset bits and any bits above the
  // SRAM word-address range are discarded.
  function automatic logic [SRAM_ADDR_W-1:0] word_addr(input logic [DATA_W-1:0] byte_addr);
    return SRAM_ADDR_W'((byte_addr - BASE) >> 2'd2);
  endfunction

  state_t state_r;
  state_t state_next_s;
  logic [CNT_W-1:0] cnt_r;

  logic mem_op_s;
  logic start_s;
  logic acked_s;
  logic timeout_s;
  logic freeze_s;

  // Fields of the instruction that is in flight, captured when it is issued.
  logic              lat_wb_r;
  logic              lat_load_r;
  logic [DATA_W-1:0] lat_alu_r;
  logic [DEST_W-1:0] lat_dest_r;

  logic                   sram_req_r;
  logic                   sram_we_r;
  logic [SRAM_ADDR_W-1:0] sram_addr_r;
  logic [DATA_W-1:0]      sram_wdata_r;
  logic                   mem_err_r;

  logic              wb_en_r;
  logic              mem_r_en_r;
  logic [DATA_W-1:0] alu_res_r;
  logic [DATA_W-1:0] mem_data_r;
  logic [DEST_W-1:0] dest_r;

  assign mem_op_s = mem_r_en_in | mem_w_en_in;

  // Next-state logic plus decode of the issue, ack, abort and stall conditions
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    acked_s      = 1'b0;
    timeout_s    = 1'b0;
    freeze_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // A stray sram_ack in IDLE is deliberately ignored here.
        if (mem_op_s) begin
          start_s      = 1'b1;
          freeze_s     = 1'b1;
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        // If ack and timeout coincide, the ack takes priority.
        if (sram_ack) begin
          acked_s      = 1'b1;
          state_next_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          freeze_s     = 1'b1;
          state_next_s = WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Count the WAIT cycles of the current access; clear the count whenever WAIT is left
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if ((state_r == WAIT) && (state_next_s == WAIT)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= '0;
    end
  end

  // SRAM request and latched instruction fields: capture at issue, hold during WAIT, drop req on ack or abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_req_r   <= 1'b0;
      sram_we_r    <= 1'b0;
      sram_addr_r  <= '0;
      sram_wdata_r <= '0;
      lat_wb_r     <= 1'b0;
      lat_load_r   <= 1'b0;
      lat_alu_r    <= '0;
      lat_dest_r   <= '0;
    end else if (start_s) begin
      // When load and store are both set, the store wins.
      sram_req_r   <= 1'b1;
      sram_we_r    <= mem_w_en_in;
      sram_addr_r  <= word_addr(alu_res_in);
      sram_wdata_r <= val_Rm_in;
      lat_wb_r     <= wb_en_in;
      lat_load_r   <= mem_r_en_in & ~mem_w_en_in;
      lat_alu_r    <= alu_res_in;
      lat_dest_r   <= dest_in;
    end else if (acked_s || timeout_s) begin
      sram_req_r   <= 1'b0;
    end else begin
      sram_req_r   <= sram_req_r;
    end
  end

  // One-cycle error pulse following an abandoned access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_err_r <= 1'b0;
    end else begin
      mem_err_r <= timeout_s;
    end
  end

  // MEM/WB register: bubble while stalled or aborted, latched fields on ack, live inputs otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_r    <= 1'b0;
      mem_r_en_r <= 1'b0;
      alu_res_r  <= '0;
      mem_data_r <= '0;
      dest_r     <= '0;
    end else if (freeze_s || timeout_s) begin
      wb_en_r    <= 1'b0;
      mem_r_en_r <= 1'b0;
      alu_res_r  <= '0;
      mem_data_r <= '0;
      dest_r     <= '0;
    end else if (acked_s) begin
      wb_en_r    <= lat_wb_r;
      mem_r_en_r <= lat_load_r;
      alu_res_r  <= lat_alu_r;
      mem_data_r <= lat_load_r ? sram_rdata : '0;
      dest_r     <= lat_dest_r;
    end else begin
      wb_en_r    <= wb_en_in;
      mem_r_en_r <= 1'b0;
      alu_res_r  <= alu_res_in;
      mem_data_r <= '0;
      dest_r     <= dest_in;
    end
  end

  // freeze is combinational so the upstream stages stall in the same cycle;
  // it is forced low while reset is asserted.
  assign freeze       = rst & freeze_s;
  assign sram_req     = sram_req_r;
  assign sram_we      = sram_we_r;
  assign sram_addr    = sram_addr_r;
  assign sram_wdata   = sram_wdata_r;
  assign mem_err      = mem_err_r;
  assign wb_en_out    = wb_en_r;
  assign mem_r_en_out = mem_r_en_r;
  assign alu_res_out  = alu_res_r;
  assign mem_data_out = mem_data_r;
  assign dest_out     = dest_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of mem_access_stage
// against a per-instruction reference model. An instruction runs for a
// known number of cycles. All but the final cycle freeze and emit a
// bubble. The final cycle retires the result, or retires a bubble after
// an abort.
module tb_mem_access_stage;

  localparam int DATA_W   = 32;
  localparam int DEST_W   = 4;
  localparam int AW       = 16;
  localparam int MEM_BASE = 1024;
  localparam int TIMEOUT  = 4;

  typedef struct packed {
    logic              wb;
    logic              mr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } wb_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic [DATA_W-1:0] alu_res_in = '0, val_Rm_in = '0, sram_rdata = '0;
  logic [DEST_W-1:0] dest_in = '0;
  logic              sram_ack = 1'b0;
  logic              sram_req, sram_we, freeze, mem_err;
  logic [AW-1:0]     sram_addr;
  logic [DATA_W-1:0] sram_wdata, alu_res_out, mem_data_out;
  logic              wb_en_out, mem_r_en_out;
  logic [DEST_W-1:0] dest_out;

  int total = 0;
  int bad   = 0;

  wb_t               cur;        // expected MEM/WB register contents this cycle
  logic [AW-1:0]     exp_addr;
  logic              exp_we;
  logic [DATA_W-1:0] exp_wdata;
  bit                last_to = 1'b0;

  mem_access_stage #(
    .DATA_W(DATA_W), .DEST_W(DEST_W), .SRAM_ADDR_W(AW),
    .MEM_BASE(MEM_BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in), .dest_in(dest_in),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack),
    .freeze(freeze), .mem_err(mem_err),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
    .mem_data_out(mem_data_out), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive ack/rdata, check everything mid-cycle, then advance.
  task automatic step(input bit fz, input bit req, input bit err, input bit ack,
                      input logic [DATA_W-1:0] rd, input wb_t nxt);
    sram_ack   = ack;
    sram_rdata = rd;
    @(negedge clk);
    check("freeze", freeze, fz);
    check("sram_req", sram_req, req);
    check("mem_err", mem_err, err);
    check("wb_en_out", wb_en_out, cur.wb);
    check("mem_r_en_out", mem_r_en_out, cur.mr);
    check("alu_res_out", alu_res_out, cur.alu);
    check("mem_data_out", mem_data_out, cur.data);
    check("dest_out", dest_out, cur.dest);
    if (req) begin
      check("sram_addr", sram_addr, exp_addr);
      check("sram_we", sram_we, exp_we);
      check("sram_wdata", sram_wdata, exp_wdata);
    end
    @(posedge clk);
    #1;
    cur = nxt;
  endtask

  // Present one instruction and run it to retirement.
  // n: WAIT cycles before ack; to: never ack; ack0: stray ack in the first cycle.
  task automatic do_instr(input logic wb, input logic mr, input logic mw,
                          input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] val,
                          input logic [DEST_W-1:0] dest, input int n, input bit to,
                          input bit ack0);
    wb_t               bub;
    wb_t               res;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] rd;
    bit                err_first;
    bub         = '0;
    wb_en_in    = wb;
    mem_r_en_in = mr;
    mem_w_en_in = mw;
    alu_res_in  = alu;
    val_Rm_in   = val;
    dest_in     = dest;
    err_first   = last_to;
    last_to     = 1'b0;
    if (!(mr | mw)) begin
      res = '{wb: wb, mr: 1'b0, alu: alu, data: '0, dest: dest};
      step(1'b0, 1'b0, err_first, ack0, $urandom(), res);
    end else begin
      diff      = alu - DATA_W'(MEM_BASE);
      exp_addr  = diff[AW+1:2];
      exp_we    = mw;
      exp_wdata = val;
      step(1'b1, 1'b0, err_first, ack0, $urandom(), bub);
      if (to) begin
        for (int k = 0; k < TIMEOUT - 1; k++) step(1'b1, 1'b1, 1'b0, 1'b0, $urandom(), bub);
        step(1'b0, 1'b1, 1'b0, 1'b0, $urandom(), bub);
        last_to = 1'b1;
      end else begin
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 1'b0, $urandom(), bub);
        rd  = $urandom();
        res = '{wb: wb, mr: mr & ~mw, alu: alu, data: (mw ? '0 : rd), dest: dest};
        step(1'b0, 1'b1, 1'b0, 1'b1, rd, res);
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] a;
    int                kind;
    cur = '0;
    // Reset with a load presented: everything, including freeze, must be 0.
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; alu_res_in = 32'd1032; dest_in = 4'd7;
    #1;
    check("rst_freeze", freeze, 1'b0);
    check("rst_req", sram_req, 1'b0);
    check("rst_wb_en", wb_en_out, 1'b0);
    check("rst_alu", alu_res_out, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // ADD, LDR (3 wait cycles), STR (immediate ack), timeout, then a normal op.
    do_instr(1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 4'd3, 0, 1'b0, 1'b0);
    do_instr(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd2, 3, 1'b0, 1'b0);
    do_instr(1'b0, 1'b0, 1'b1, 32'd1024, 32'h12345678, 4'd0, 0, 1'b0, 1'b0);
    do_instr(1'b1, 1'b1, 1'b0, 32'd2000, 32'h0, 4'd5, 0, 1'b1, 1'b0);
    do_instr(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd9, 0, 1'b0, 1'b1);
    // Ack in the last allowed WAIT cycle beats the timeout; load+store acts as a store.
    do_instr(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd4, TIMEOUT - 1, 1'b0, 1'b0);
    do_instr(1'b1, 1'b1, 1'b1, 32'd1043, 32'hCAFEF00D, 4'd6, 1, 1'b0, 1'b0);
    // Back-to-back LDR then STR.
    do_instr(1'b1, 1'b1, 1'b0, 32'd1100, 32'h0, 4'd1, 2, 1'b0, 1'b0);
    do_instr(1'b0, 1'b0, 1'b1, 32'd1104, 32'hA5A5A5A5, 4'd0, 1, 1'b0, 1'b0);

    // Reset in the middle of WAIT.
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0; alu_res_in = 32'd1060; dest_in = 4'd8;
    sram_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_req", sram_req, 1'b0);
    check("midrst_freeze", freeze, 1'b0);
    check("midrst_err", mem_err, 1'b0);
    check("midrst_wb_en", wb_en_out, 1'b0);
    check("midrst_dest", dest_out, 4'd0);
    @(posedge clk); #1;
    rst     = 1'b1;
    cur     = '0;
    last_to = 1'b0;
    do_instr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd2, 0, 1'b0, 1'b1);
    do_instr(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd3, 0, 1'b0, 1'b0);

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      a    = ($urandom_range(0, 1) == 0) ? (32'd1024 + 32'($urandom_range(0, 4095))) : 32'($urandom());
      case (kind)
        0: do_instr(1'($urandom()), 1'b0, 1'b0, a, $urandom(), 4'($urandom()), 0, 1'b0, 1'($urandom()));
        1: do_instr(1'($urandom()), 1'b1, 1'b0, a, $urandom(), 4'($urandom()),
                    $urandom_range(0, TIMEOUT - 1), ($urandom_range(0, 5) == 0), 1'($urandom()));
        2: do_instr(1'($urandom()), 1'b0, 1'b1, a, $urandom(), 4'($urandom()),
                    $urandom_range(0, TIMEOUT - 1), ($urandom_range(0, 5) == 0), 1'($urandom()));
        default: do_instr(1'($urandom()), 1'b1, 1'b1, a, $urandom(), 4'($urandom()),
                          $urandom_range(0, TIMEOUT - 1), ($urandom_range(0, 5) == 0), 1'($urandom()));
      endcase
    end
    // Trailing no-op so a final abort's error pulse is also checked.
    do_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 0, 1'b0, 1'b0);
    do_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
